// File: rtl/regfile_alu_sequencer_pkg.sv
// Shared definitions for the register-file/ALU sequencer: instruction layout,
// instruction kinds and FSM state encoding.
package regfile_alu_sequencer_pkg;

   localparam int INSTR_W = 14;

   // Instruction field bit positions
   localparam int KIND_BIT = 13;
   localparam int OPER_HI  = 12;
   localparam int OPER_LO  = 10;
   localparam int RS1_HI   = 9;
   localparam int RS1_LO   = 8;
   localparam int RS2_HI   = 7;
   localparam int RS2_LO   = 6;
   localparam int RD_HI    = 5;
   localparam int RD_LO    = 4;
   localparam int IMM_HI   = 3;
   localparam int IMM_LO   = 0;

   localparam logic KIND_ALU  = 1'b0;
   localparam logic KIND_LOAD = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   typedef struct packed {
      logic       kind;
      logic [2:0] oper;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [1:0] rd;
      logic [3:0] imm;
   } instr_f_t;

endpackage

// File: rtl/regfile_alu_sequencer_instr_decode.sv
// Splits the latched instruction word into its named fields.
module instr_decode
   import regfile_alu_sequencer_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output instr_f_t           f
);

   // Pure field extraction, no logic
   always_comb begin
      f      = '0;
      f.kind = ir[KIND_BIT];
      f.oper = ir[OPER_HI:OPER_LO];
      f.rs1  = ir[RS1_HI:RS1_LO];
      f.rs2  = ir[RS2_HI:RS2_LO];
      f.rd   = ir[RD_HI:RD_LO];
      f.imm  = ir[IMM_HI:IMM_LO];
   end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// Sequencer driving a register file and ALU: LOAD writes an immediate,
// ALU instructions read two operands, execute and write back the result.
module regfile_alu_sequencer
   import regfile_alu_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [1:0]         rd1,
   output logic [1:0]         rd2,
   output logic [1:0]         wr,
   output logic [2:0]         oper,
   output logic               src_sel,
   output logic               reg_we,
   output logic [3:0]         data_out,
   input  logic               carry_in,
   output logic               carry_flag,
   output logic               busy,
   output logic               done,
   output logic [7:0]         retire_cnt
);

   state_t             state, state_nxt;
   logic [INSTR_W-1:0] ir;
   instr_f_t           f;
   logic               hs;

   instr_decode u_dec (
      .ir (ir),
      .f  (f)
   );

   // Handshake only depends on state, so instr_ready has no path from instr_in
   assign hs = instr_valid && (state == ST_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state and decoded datapath controls
   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      busy        = 1'b1;
      rd1         = '0;
      rd2         = '0;
      wr          = '0;
      oper        = '0;
      src_sel     = 1'b0;
      reg_we      = 1'b0;
      data_out    = '0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            if (instr_valid)
               state_nxt = (instr_in[KIND_BIT] == KIND_LOAD) ? ST_WB : ST_READ;
         end
         ST_READ, ST_EXEC: begin
            rd1       = f.rs1;
            rd2       = f.rs2;
            oper      = f.oper;
            state_nxt = (state == ST_READ) ? ST_EXEC : ST_WB;
         end
         ST_WB: begin
            wr        = f.rd;
            reg_we    = 1'b1;
            state_nxt = ST_IDLE;
            if (f.kind == KIND_LOAD) begin
               src_sel  = 1'b1;
               data_out = f.imm;
            end else begin
               // Keep operands and op steady so the ALU result is stable at the write edge
               rd1  = f.rs1;
               rd2  = f.rs2;
               oper = f.oper;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Instruction register: loaded only on handshake
   always_ff @(posedge clk) begin
      if (reset)   ir <= '0;
      else if (hs) ir <= instr_in;
   end

   // Carry flag: captured on the edge leaving EXEC; LOAD never reaches EXEC
   always_ff @(posedge clk) begin
      if (reset)                  carry_flag <= 1'b0;
      else if (state == ST_EXEC)  carry_flag <= carry_in;
   end

   // Retire pulse and counter, both stepped on the edge leaving WB
   always_ff @(posedge clk) begin
      if (reset) begin
         done       <= 1'b0;
         retire_cnt <= '0;
      end else begin
         done <= (state == ST_WB);
         if (state == ST_WB) retire_cnt <= retire_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed self-checking bench for regfile_alu_sequencer.
module tb_regfile_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  rd1, rd2, wr;
   logic [2:0]  oper;
   logic        src_sel, reg_we;
   logic [3:0]  data_out;
   logic        carry_in;
   logic        carry_flag, busy, done;
   logic [7:0]  retire_cnt;

   int checks   = 0;
   int failures = 0;

   regfile_alu_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .rd1         (rd1),
      .rd2         (rd2),
      .wr          (wr),
      .oper        (oper),
      .src_sel     (src_sel),
      .reg_we      (reg_we),
      .data_out    (data_out),
      .carry_in    (carry_in),
      .carry_flag  (carry_flag),
      .busy        (busy),
      .done        (done),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] mk(input logic kind, input logic [2:0] op,
                                      input logic [1:0] s1, input logic [1:0] s2,
                                      input logic [1:0] d, input logic [3:0] imm);
      return {kind, op, s1, s2, d, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {rd1,rd2,wr,oper,src_sel,reg_we,data_out} packed into 15 bits
   function automatic logic [15:0] ctl();
      return {1'b0, rd1, rd2, wr, oper, src_sel, reg_we, data_out};
   endfunction

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr_in = '0; carry_in = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_ready", instr_ready, 1);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_cnt",   retire_cnt, 0);
      chk("rst_carry", carry_flag, 0);
      chk("rst_ctl",   ctl(), 0);

      // LOAD imm=A rd=2
      instr_in = mk(1, 3'd0, 2'd0, 2'd0, 2'd2, 4'hA); instr_valid = 1'b1;
      step();
      instr_valid = 1'b0; instr_in = '0;
      chk("ld_wb_ctl",   ctl(), {1'b0, 2'd0, 2'd0, 2'd2, 3'd0, 1'b1, 1'b1, 4'hA});
      chk("ld_wb_ready", instr_ready, 0);
      chk("ld_wb_busy",  busy, 1);
      chk("ld_wb_done",  done, 0);
      step();
      chk("ld_done",     done, 1);
      chk("ld_cnt",      retire_cnt, 1);
      chk("ld_idle_ctl", ctl(), 0);
      step();
      chk("ld_done_clr", done, 0);

      // ALU op=0 rs1=1 rs2=2 rd=3, carry_in=0
      instr_in = mk(0, 3'd0, 2'd1, 2'd2, 2'd3, 4'h0); instr_valid = 1'b1;
      step();
      instr_valid = 1'b0; instr_in = mk(1, 3'd7, 2'd3, 2'd3, 2'd1, 4'hF);
      chk("alu_rd_ctl",  ctl(), {1'b0, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 4'h0});
      chk("alu_rd_busy", busy, 1);
      step();
      chk("alu_ex_ctl",  ctl(), {1'b0, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 4'h0});
      step();
      chk("alu_wb_ctl",  ctl(), {1'b0, 2'd1, 2'd2, 2'd3, 3'd0, 1'b0, 1'b1, 4'h0});
      chk("alu_wb_done", done, 0);
      step();
      chk("alu_done",    done, 1);
      chk("alu_we_off",  reg_we, 0);
      chk("alu_cnt",     retire_cnt, 2);
      chk("alu_carry0",  carry_flag, 0);

      // ALU op=5 with carry_in=1 from READ onward; flag must only move leaving EXEC
      instr_in = mk(0, 3'd5, 2'd3, 2'd0, 2'd1, 4'h0); instr_valid = 1'b1;
      step();
      instr_valid = 1'b0; carry_in = 1'b1;
      step();
      chk("cy_ex_flag",  carry_flag, 0);
      chk("cy_ex_oper",  oper, 5);
      step();
      carry_in = 1'b0;
      chk("cy_wb_flag",  carry_flag, 1);
      chk("cy_wb_oper",  oper, 5);
      chk("cy_wb_wr",    wr, 1);
      step();
      chk("cy_cnt",      retire_cnt, 3);
      // LOAD afterward leaves carry alone
      instr_in = mk(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h3); instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
      chk("cy_ld_flag",  carry_flag, 1);
      chk("cy_ld_cnt",   retire_cnt, 4);

      // Three back-to-back LOADs with valid held high
      instr_in = mk(1, 3'd0, 2'd0, 2'd0, 2'd1, 4'h1); instr_valid = 1'b1;
      step();
      instr_in = mk(1, 3'd0, 2'd0, 2'd0, 2'd2, 4'h2);
      chk("b2b_1_ready", instr_ready, 0);
      chk("b2b_1_data",  data_out, 4'h1);
      chk("b2b_1_wr",    wr, 1);
      step();
      chk("b2b_1_done",  done, 1);
      chk("b2b_1_rdy",   instr_ready, 1);
      chk("b2b_1_cnt",   retire_cnt, 5);
      step();
      instr_in = mk(1, 3'd0, 2'd0, 2'd0, 2'd3, 4'h3);
      chk("b2b_2_data",  data_out, 4'h2);
      chk("b2b_2_we",    reg_we, 1);
      step();
      chk("b2b_2_done",  done, 1);
      chk("b2b_2_cnt",   retire_cnt, 6);
      step();
      instr_valid = 1'b0;
      chk("b2b_3_data",  data_out, 4'h3);
      chk("b2b_3_wr",    wr, 3);
      step();
      chk("b2b_3_done",  done, 1);
      chk("b2b_3_cnt",   retire_cnt, 7);
      step();
      chk("b2b_idle",    busy, 0);

      // Reset during EXEC aborts the instruction
      instr_in = mk(0, 3'd2, 2'd1, 2'd1, 2'd0, 4'h0); instr_valid = 1'b1;
      step();
      instr_valid = 1'b0; carry_in = 1'b1;
      step();
      chk("ab_ex_busy",  busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0; carry_in = 1'b0;
      chk("ab_busy",     busy, 0);
      chk("ab_we",       reg_we, 0);
      chk("ab_done",     done, 0);
      chk("ab_cnt",      retire_cnt, 0);
      chk("ab_carry",    carry_flag, 0);
      step();
      chk("ab_done2",    done, 0);
      chk("ab_we2",      reg_we, 0);

      // Reset wins over a simultaneous handshake
      instr_in = mk(1, 3'd0, 2'd0, 2'd0, 2'd1, 4'h9); instr_valid = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; instr_valid = 1'b0;
      chk("rp_busy",     busy, 0);
      chk("rp_ctl",      ctl(), 0);
      step();
      chk("rp_done",     done, 0);
      chk("rp_cnt",      retire_cnt, 0);

      // 256 LOADs: counter wraps to 0
      instr_in = mk(1, 3'd0, 2'd0, 2'd0, 2'd2, 4'h5); instr_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         step();
         if (i == 255) instr_valid = 1'b0;
         chk("wrap_we", reg_we, 1);
         step();
         if (i == 254) chk("wrap_255", retire_cnt, 8'd255);
      end
      chk("wrap_cnt",  retire_cnt, 0);
      chk("wrap_done", done, 1);
      step();
      chk("wrap_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
